// File: rtl/secuenciador_alu_pkg.sv
// Shared types and constants for the condition-gated ALU sequencer:
// FSM states, ARM condition codes and status-register bit positions.
package secuenciador_alu_pkg;

    typedef enum logic [1:0] {
        REPOSO,
        EVALUAR,
        EJECUTAR,
        RESPUESTA
    } estado_t;

    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Status register layout is {N,Z,C,V}
    localparam int NZCV_N = 3;
    localparam int NZCV_Z = 2;
    localparam int NZCV_C = 1;
    localparam int NZCV_V = 0;

endpackage

// File: rtl/secuenciador_alu_if.sv
// Request/response handshake bundle between a requester (master)
// and the sequencer (slave).
interface secuenciador_alu_if #(parameter int N = 8);
    logic         sol_valido;
    logic         sol_listo;
    logic [N-1:0] sol_a;
    logic [N-1:0] sol_b;
    logic [3:0]   sol_operacion;
    logic [3:0]   sol_condicion;
    logic         sol_actualizar;
    logic         res_valido;
    logic         res_listo;
    logic [N-1:0] res_resultado;
    logic         res_ejecutado;

    modport master (
        output sol_valido, sol_a, sol_b, sol_operacion, sol_condicion, sol_actualizar, res_listo,
        input  sol_listo, res_valido, res_resultado, res_ejecutado
    );

    modport slave (
        input  sol_valido, sol_a, sol_b, sol_operacion, sol_condicion, sol_actualizar, res_listo,
        output sol_listo, res_valido, res_resultado, res_ejecutado
    );
endinterface

// File: rtl/secuenciador_alu_evaluador_condicion.sv
// Combinational ARM condition-field check against the current {N,Z,C,V}.
module evaluador_condicion
    import secuenciador_alu_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] nzcv,
    output logic       pasa
);
    logic n, z, c, v;

    assign n = nzcv[NZCV_N];
    assign z = nzcv[NZCV_Z];
    assign c = nzcv[NZCV_C];
    assign v = nzcv[NZCV_V];

    always_comb begin
        pasa = 1'b1;
        case (cond)
            COND_EQ: pasa = z;
            COND_NE: pasa = ~z;
            COND_CS: pasa = c;
            COND_CC: pasa = ~c;
            COND_MI: pasa = n;
            COND_PL: pasa = ~n;
            COND_VS: pasa = v;
            COND_VC: pasa = ~v;
            COND_HI: pasa = c & ~z;
            COND_LS: pasa = ~c | z;
            COND_GE: pasa = (n == v);
            COND_LT: pasa = (n != v);
            COND_GT: pasa = ~z & (n == v);
            COND_LE: pasa = z | (n != v);
            default: pasa = 1'b1;
        endcase
    end
endmodule

// File: rtl/secuenciador_alu.sv
// Single-request sequencer: latch a request, gate it on the ARM condition,
// run it through an external combinational ALU and hold the response.
module secuenciador_alu
    import secuenciador_alu_pkg::*;
#(
    parameter int N = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    secuenciador_alu_if.slave   bus,
    output logic [N-1:0]        alu_op1,
    output logic [N-1:0]        alu_op2,
    output logic [3:0]          alu_control,
    input  logic [N-1:0]        alu_resultado,
    input  logic                alu_n,
    input  logic                alu_z,
    input  logic                alu_v,
    input  logic                alu_c,
    output logic [3:0]          nzcv
);
    estado_t      state_reg, state_next;
    logic [N-1:0] op1_reg, op2_reg, resultado_reg;
    logic [3:0]   control_reg, cond_reg, nzcv_reg;
    logic         actualizar_reg, ejecutado_reg;
    logic         pasa;

    evaluador_condicion u_evaluador (
        .cond (cond_reg),
        .nzcv (nzcv_reg),
        .pasa (pasa)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= REPOSO;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            REPOSO:    if (bus.sol_valido) state_next = EVALUAR;
            EVALUAR:   state_next = pasa ? EJECUTAR : RESPUESTA;
            EJECUTAR:  state_next = RESPUESTA;
            RESPUESTA: if (bus.res_listo) state_next = REPOSO;
            default:   state_next = REPOSO;
        endcase
    end

    // Request fields are only captured in REPOSO, so stray sol_valido pulses
    // while busy never disturb the operands the ALU is looking at.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op1_reg        <= '0;
            op2_reg        <= '0;
            control_reg    <= '0;
            cond_reg       <= '0;
            actualizar_reg <= 1'b0;
            resultado_reg  <= '0;
            ejecutado_reg  <= 1'b0;
            nzcv_reg       <= 4'b0000;
        end else begin
            case (state_reg)
                REPOSO: if (bus.sol_valido) begin
                    op1_reg        <= bus.sol_a;
                    op2_reg        <= bus.sol_b;
                    control_reg    <= bus.sol_operacion;
                    cond_reg       <= bus.sol_condicion;
                    actualizar_reg <= bus.sol_actualizar;
                end
                EVALUAR: if (!pasa) begin
                    resultado_reg <= '0;
                    ejecutado_reg <= 1'b0;
                end
                EJECUTAR: begin
                    resultado_reg <= alu_resultado;
                    ejecutado_reg <= 1'b1;
                    if (actualizar_reg) nzcv_reg <= {alu_n, alu_z, alu_c, alu_v};
                end
                default: ;
            endcase
        end
    end

    assign bus.sol_listo     = (state_reg == REPOSO);
    assign bus.res_valido    = (state_reg == RESPUESTA);
    assign bus.res_resultado = resultado_reg;
    assign bus.res_ejecutado = ejecutado_reg;
    assign alu_op1           = op1_reg;
    assign alu_op2           = op2_reg;
    assign alu_control       = control_reg;
    assign nzcv              = nzcv_reg;
endmodule

// File: tb/tb_secuenciador_alu.sv
// Directed bench for secuenciador_alu: a vector table of requests with
// hand-computed results, plus back-pressure and mid-operation reset sequences.
module tb_secuenciador_alu;
    localparam int N = 8;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b1000;
    localparam logic [3:0] OP_SUB = 4'b1001;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [N-1:0] alu_op1, alu_op2, alu_resultado;
    logic [3:0]   alu_control, nzcv;
    logic         alu_n, alu_z, alu_v, alu_c;

    secuenciador_alu_if #(.N(N)) bus ();

    secuenciador_alu #(.N(N)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .alu_op1       (alu_op1),
        .alu_op2       (alu_op2),
        .alu_control   (alu_control),
        .alu_resultado (alu_resultado),
        .alu_n         (alu_n),
        .alu_z         (alu_z),
        .alu_v         (alu_v),
        .alu_c         (alu_c),
        .nzcv          (nzcv)
    );

    always #5 clk = ~clk;

    // External ALU: ADD, SUB (C = no borrow), AND, otherwise OR
    logic [N:0] ancho;
    always_comb begin
        ancho         = '0;
        alu_resultado = '0;
        alu_c         = 1'b0;
        alu_v         = 1'b0;
        case (alu_control)
            OP_ADD: begin
                ancho         = {1'b0, alu_op1} + {1'b0, alu_op2};
                alu_resultado = ancho[N-1:0];
                alu_c         = ancho[N];
                alu_v         = (alu_op1[N-1] == alu_op2[N-1]) && (alu_resultado[N-1] != alu_op1[N-1]);
            end
            OP_SUB: begin
                ancho         = {1'b0, alu_op1} - {1'b0, alu_op2};
                alu_resultado = ancho[N-1:0];
                alu_c         = ~ancho[N];
                alu_v         = (alu_op1[N-1] != alu_op2[N-1]) && (alu_resultado[N-1] != alu_op1[N-1]);
            end
            OP_AND:  alu_resultado = alu_op1 & alu_op2;
            default: alu_resultado = alu_op1 | alu_op2;
        endcase
        alu_n = alu_resultado[N-1];
        alu_z = (alu_resultado == '0);
    end

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [3:0]   op;
        logic [3:0]   cond;
        logic         s;
        logic [N-1:0] exp_res;
        logic         exp_ej;
        logic [3:0]   exp_nzcv;
        int           exp_lat;
    } vector_t;

    vector_t vec [20];
    int errores = 0;
    int checks  = 0;

    task automatic chk(input string nombre, input logic [31:0] actual, input logic [31:0] esperado);
        checks++;
        if (actual !== esperado) begin
            errores++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nombre, actual, esperado);
        end
    endtask

    task automatic solicitud(input logic [N-1:0] a, input logic [N-1:0] b, input logic [3:0] op,
                             input logic [3:0] cond, input logic s,
                             output logic [N-1:0] res, output logic ej, output logic [3:0] nz,
                             output int lat);
        logic v;
        @(negedge clk);
        chk("sol_listo_idle", 32'(bus.sol_listo), 32'd1);
        bus.sol_a          = a;
        bus.sol_b          = b;
        bus.sol_operacion  = op;
        bus.sol_condicion  = cond;
        bus.sol_actualizar = s;
        bus.sol_valido     = 1'b1;
        @(posedge clk);
        #1 bus.sol_valido  = 1'b0;
        lat = 0;
        v   = 1'b0;
        while (!v && lat < 10) begin
            @(negedge clk);
            lat++;
            v = bus.res_valido;
        end
        if (!v) begin
            errores++;
            checks++;
            $display("FAIL res_valido_timeout: got 0 expected 1");
        end
        res = bus.res_resultado;
        ej  = bus.res_ejecutado;
        nz  = nzcv;
        bus.res_listo = 1'b1;
        @(posedge clk);
        #1 bus.res_listo = 1'b0;
    endtask

    initial begin
        logic [N-1:0] res;
        logic         ej;
        logic [3:0]   nz;
        int           lat;
        int           visto;

        vec[0]  = '{8'h7F, 8'h01, OP_ADD, 4'b1110, 1'b1, 8'h80, 1'b1, 4'b1001, 3};
        vec[1]  = '{8'h10, 8'h20, OP_ADD, 4'b0110, 1'b0, 8'h30, 1'b1, 4'b1001, 3};
        vec[2]  = '{8'h10, 8'h20, OP_ADD, 4'b0111, 1'b0, 8'h00, 1'b0, 4'b1001, 2};
        vec[3]  = '{8'h05, 8'h05, OP_SUB, 4'b1110, 1'b1, 8'h00, 1'b1, 4'b0110, 3};
        vec[4]  = '{8'h03, 8'h04, OP_ADD, 4'b0000, 1'b0, 8'h07, 1'b1, 4'b0110, 3};
        vec[5]  = '{8'h03, 8'h04, OP_ADD, 4'b0001, 1'b0, 8'h00, 1'b0, 4'b0110, 2};
        vec[6]  = '{8'h03, 8'h04, OP_ADD, 4'b0010, 1'b0, 8'h07, 1'b1, 4'b0110, 3};
        vec[7]  = '{8'h03, 8'h04, OP_ADD, 4'b1000, 1'b0, 8'h00, 1'b0, 4'b0110, 2};
        vec[8]  = '{8'h03, 8'h04, OP_ADD, 4'b1001, 1'b0, 8'h07, 1'b1, 4'b0110, 3};
        vec[9]  = '{8'h03, 8'h05, OP_SUB, 4'b1110, 1'b1, 8'hFE, 1'b1, 4'b1000, 3};
        vec[10] = '{8'h01, 8'h01, OP_ADD, 4'b1010, 1'b0, 8'h00, 1'b0, 4'b1000, 2};
        vec[11] = '{8'h01, 8'h01, OP_ADD, 4'b1011, 1'b0, 8'h02, 1'b1, 4'b1000, 3};
        vec[12] = '{8'h01, 8'h01, OP_ADD, 4'b0100, 1'b0, 8'h02, 1'b1, 4'b1000, 3};
        vec[13] = '{8'h01, 8'h01, OP_ADD, 4'b1100, 1'b0, 8'h00, 1'b0, 4'b1000, 2};
        vec[14] = '{8'h01, 8'h01, OP_ADD, 4'b1101, 1'b0, 8'h02, 1'b1, 4'b1000, 3};
        vec[15] = '{8'hF0, 8'h3C, OP_AND, 4'b1111, 1'b1, 8'h30, 1'b1, 4'b0000, 3};
        vec[16] = '{8'h01, 8'h01, OP_ADD, 4'b0101, 1'b0, 8'h02, 1'b1, 4'b0000, 3};
        vec[17] = '{8'h01, 8'h01, OP_ADD, 4'b0011, 1'b0, 8'h02, 1'b1, 4'b0000, 3};
        vec[18] = '{8'hFF, 8'h01, OP_ADD, 4'b1110, 1'b1, 8'h00, 1'b1, 4'b0110, 3};
        vec[19] = '{8'h01, 8'h01, OP_ADD, 4'b1010, 1'b0, 8'h02, 1'b1, 4'b0110, 3};

        bus.sol_valido = 1'b0; bus.sol_a = '0; bus.sol_b = '0;
        bus.sol_operacion = '0; bus.sol_condicion = '0; bus.sol_actualizar = 1'b0;
        bus.res_listo = 1'b0;
        rst_n = 1'b0;

        #2;
        chk("rst_sol_listo",  32'(bus.sol_listo), 32'd1);
        chk("rst_res_valido", 32'(bus.res_valido), 32'd0);
        chk("rst_ejecutado",  32'(bus.res_ejecutado), 32'd0);
        chk("rst_resultado",  32'(bus.res_resultado), 32'd0);
        chk("rst_alu_op1",    32'(alu_op1), 32'd0);
        chk("rst_alu_op2",    32'(alu_op2), 32'd0);
        chk("rst_alu_control",32'(alu_control), 32'd0);
        chk("rst_nzcv",       32'(nzcv), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector 0 is driven at the same negedge reset is released: first edge accepts
        for (int i = 0; i < 20; i++) begin
            if (i == 0) begin
                bus.sol_a = vec[0].a; bus.sol_b = vec[0].b;
                bus.sol_operacion = vec[0].op; bus.sol_condicion = vec[0].cond;
                bus.sol_actualizar = vec[0].s; bus.sol_valido = 1'b1;
                chk("sol_listo_after_rst", 32'(bus.sol_listo), 32'd1);
                @(posedge clk);
                #1 bus.sol_valido = 1'b0;
                chk("accept_first_edge", 32'(bus.sol_listo), 32'd0);
                lat = 0; ej = 1'b0;
                while (!ej && lat < 10) begin
                    @(negedge clk); lat++; ej = bus.res_valido;
                end
                res = bus.res_resultado; ej = bus.res_ejecutado; nz = nzcv;
                bus.res_listo = 1'b1;
                @(posedge clk);
                #1 bus.res_listo = 1'b0;
            end else begin
                solicitud(vec[i].a, vec[i].b, vec[i].op, vec[i].cond, vec[i].s, res, ej, nz, lat);
            end
            $display("vec %0d: cond=%b s=%b res=0x%02h ej=%b nzcv=%b lat=%0d", i, vec[i].cond, vec[i].s, res, ej, nz, lat);
            chk($sformatf("vec%0d_resultado", i), 32'(res), 32'(vec[i].exp_res));
            chk($sformatf("vec%0d_ejecutado", i), 32'(ej), 32'(vec[i].exp_ej));
            chk($sformatf("vec%0d_nzcv", i), 32'(nz), 32'(vec[i].exp_nzcv));
            chk($sformatf("vec%0d_latencia", i), 32'(lat), 32'(vec[i].exp_lat));
        end

        // Back-pressure: hold res_listo low while poking sol_valido
        @(negedge clk);
        bus.sol_a = 8'h11; bus.sol_b = 8'h22; bus.sol_operacion = OP_ADD;
        bus.sol_condicion = 4'b1110; bus.sol_actualizar = 1'b0; bus.sol_valido = 1'b1;
        @(posedge clk);
        #1 bus.sol_valido = 1'b0;
        lat = 0; ej = 1'b0;
        while (!ej && lat < 10) begin
            @(negedge clk); lat++; ej = bus.res_valido;
        end
        chk("hold_latencia", 32'(lat), 32'd3);
        for (int k = 0; k < 5; k++) begin
            if (k > 0) @(negedge clk);
            chk("hold_res_valido", 32'(bus.res_valido), 32'd1);
            chk("hold_resultado",  32'(bus.res_resultado), 32'h33);
            chk("hold_ejecutado",  32'(bus.res_ejecutado), 32'd1);
            chk("hold_sol_listo",  32'(bus.sol_listo), 32'd0);
            bus.sol_a = 8'hAA; bus.sol_b = 8'hBB; bus.sol_valido = (k % 2 == 0);
        end
        bus.sol_valido = 1'b0;
        $display("hold: res=0x%02h held 5 cycles, alu_op1=0x%02h", bus.res_resultado, alu_op1);
        chk("hold_ignored_op1", 32'(alu_op1), 32'h11);
        chk("hold_nzcv", 32'(nzcv), 32'b0110);
        bus.res_listo = 1'b1;
        @(posedge clk);
        #1 bus.res_listo = 1'b0;
        chk("hold_back_to_idle", 32'(bus.sol_listo), 32'd1);

        // Reset during EJECUTAR aborts the request without committing flags
        @(negedge clk);
        bus.sol_a = 8'h7F; bus.sol_b = 8'h01; bus.sol_operacion = OP_ADD;
        bus.sol_condicion = 4'b1110; bus.sol_actualizar = 1'b1; bus.sol_valido = 1'b1;
        @(posedge clk);
        #1 bus.sol_valido = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("abort_in_ejecutar", 32'(alu_control), 32'(OP_ADD));
        rst_n = 1'b0;
        #1;
        chk("abort_sol_listo",  32'(bus.sol_listo), 32'd1);
        chk("abort_res_valido", 32'(bus.res_valido), 32'd0);
        chk("abort_nzcv",       32'(nzcv), 32'd0);
        chk("abort_alu_op1",    32'(alu_op1), 32'd0);
        chk("abort_ejecutado",  32'(bus.res_ejecutado), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        visto = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (bus.res_valido) visto++;
        end
        $display("abort: nzcv=%b res_valido seen %0d times", nzcv, visto);
        chk("abort_no_response", 32'(visto), 32'd0);
        chk("abort_nzcv_after", 32'(nzcv), 32'd0);

        solicitud(8'h02, 8'h03, OP_ADD, 4'b1110, 1'b0, res, ej, nz, lat);
        $display("recover: res=0x%02h ej=%b nzcv=%b lat=%0d", res, ej, nz, lat);
        chk("recover_resultado", 32'(res), 32'h05);
        chk("recover_ejecutado", 32'(ej), 32'd1);
        chk("recover_nzcv", 32'(nz), 32'd0);
        chk("recover_latencia", 32'(lat), 32'd3);

        $display("Result: errors=%0d of %0d checks", errores, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/secuenciador_alu.md
SECUENCIADOR_ALU -- requirements
Module: secuenciador_alu

Interface
REQ-001 Parameter N, default 8, datapath width in bits.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous, active-low reset.
REQ-004 sol_valido  input  1  request valid.
REQ-005 sol_listo  output  1  request ready; high only in REPOSO.
REQ-006 sol_a, sol_b  input  N each  operands.
REQ-007 sol_operacion  input  4  ALU control code, passed unchanged to alu_control.
REQ-008 sol_condicion  input  4  ARM condition field.
REQ-009 sol_actualizar  input  1  S bit; commit flags when set.
REQ-010 alu_op1, alu_op2  output  N each  operands to the ALU; alu_control output 4.
REQ-011 alu_resultado  input  N; alu_n, alu_z, alu_v, alu_c  input  1 each  ALU result and flags.
REQ-012 res_valido  output  1; res_listo  input  1  response handshake.
REQ-013 res_resultado  output  N; res_ejecutado  output  1; nzcv  output  4  status register {N,Z,C,V}.

Function
REQ-014 The FSM SHALL have states REPOSO, EVALUAR, EJECUTAR and RESPUESTA.
REQ-015 A request SHALL be accepted when sol_valido and sol_listo are high at a clock edge; operands, code, condition and S bit are latched and the state moves to EVALUAR.
REQ-016 EVALUAR SHALL evaluate the latched condition against current nzcv:
- EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V
- HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V)
- 1110 and 1111 always pass.
REQ-017 On pass, EVALUAR SHALL go to EJECUTAR.
REQ-018 On fail, EVALUAR SHALL go directly to RESPUESTA with res_ejecutado=0 and res_resultado=0; nzcv is unchanged.
REQ-019 alu_op1, alu_op2 and alu_control SHALL be driven from the latched registers in every state; the ALU path is combinational.
REQ-020 At the end of EJECUTAR, alu_resultado SHALL be captured into res_resultado and res_ejecutado set to 1.
REQ-021 At the end of EJECUTAR, nzcv SHALL load {alu_n,alu_z,alu_c,alu_v} only if the S bit is set; otherwise it holds.
REQ-022 Latency SHALL be: acceptance edge -> res_valido high 3 cycles later when executed, 2 cycles later when skipped.
REQ-023 In RESPUESTA, res_valido SHALL stay high with res_resultado and res_ejecutado stable until res_listo is sampled high; the state then returns to REPOSO.
REQ-024 At most one request SHALL be in flight; sol_valido outside REPOSO is ignored and needs no buffering.
REQ-025 nzcv SHALL change only at the end of EJECUTAR and at reset.

Reset
REQ-026 While rst_n is low, asynchronously: state=REPOSO, sol_listo=1, res_valido=0, res_ejecutado=0; res_resultado, latched operands, alu_op1, alu_op2 and alu_control = 0; nzcv=4'b0000.
REQ-027 Reset asserted mid-operation SHALL abort the request with no response and no flag commit.
REQ-028 After rst_n rises, the first acceptance is possible at the first clock edge.

Structure
REQ-029 Package secuenciador_alu_pkg SHALL hold:
- state enum
- 4-bit condition constants COND_EQ..COND_AL
- nzcv bit-index constants.
REQ-030 Condition evaluation SHALL be one combinational sub-module, evaluador_condicion (inputs: cond, nzcv; output: pasa).

Verification
REQ-031 Reset, then ADD 0x7F+0x01, cond AL, S=1, ALU code 4'b1000 -> res_resultado=0x80, ejecutado=1, nzcv=4'b1001, res_valido 3 cycles after acceptance.
REQ-032 Then request cond VS -> executed; then cond VC -> skipped, ejecutado=0, resultado=0x00, nzcv=4'b1001 unchanged, latency 2.
REQ-033 SUB 0x05-0x05, S=1 -> resultado=0x00, Z=1; then EQ executes and NE is skipped.
REQ-034 Hold res_listo low 5 cycles -> res_valido and data stable throughout, sol_listo=0, extra sol_valido pulses ignored.
REQ-035 Any op with S=0 -> nzcv unchanged from its prior value.
REQ-036 rst_n pulsed low during EJECUTAR -> immediate REPOSO, nzcv=0000, res_valido never asserted for that request.
